// File: rtl/handshake_responder_if.sv
// Handshake bundle between the 2-bit handshake controller (master) and the
// token responder (slave): start/ack requests one way, done/init/ready back.
interface handshake_responder_if;
    logic start;
    logic ack;
    logic done;
    logic init;
    logic ready;

    modport master (
        output start,
        output ack,
        input  done,
        input  init,
        input  ready
    );

    modport slave (
        input  start,
        input  ack,
        output done,
        output init,
        output ready
    );
endinterface

// File: rtl/handshake_responder.sv
// Far-end responder of the start/done/ack/init handshake. It prepares one
// result token over WORK_CYCLES cycles; a start that finds the token ready is
// answered with a one-cycle done, while a controller that missed its done
// raises ack and is answered with a one-cycle init once preparation finishes.
module handshake_responder #(
    parameter int WORK_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    handshake_responder_if.slave hs,
    output logic [2:0]           state,
    output logic [CNT_W-1:0]     served_cnt,
    output logic [CNT_W-1:0]     nack_cnt
);

    localparam int              PREP_W    = $clog2(WORK_CYCLES + 1);
    localparam logic [PREP_W-1:0] PREP_LOAD = PREP_W'(WORK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_PREP    = 3'd0,
        ST_READY   = 3'd1,
        ST_DONE    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_INIT    = 3'd4
    } state_t;

    state_t            cur_state;
    state_t            next_state;
    logic [PREP_W-1:0] prep_cnt;
    logic              prep_like;
    logic              token_hit;
    logic              token_miss;

    // Next-state decode; ack wins over start, and unused codes behave as PREP.
    always_comb begin
        next_state = ST_PREP;
        prep_like  = 1'b0;
        token_hit  = 1'b0;
        token_miss = 1'b0;
        case (cur_state)
            ST_READY: begin
                if (hs.ack) begin
                    next_state = ST_INIT;
                    token_miss = 1'b1;
                end else if (hs.start) begin
                    next_state = ST_DONE;
                    token_hit  = 1'b1;
                end else begin
                    next_state = ST_READY;
                end
            end
            ST_DONE:    next_state = ST_PREP;
            ST_RECOVER: next_state = (prep_cnt == '0) ? ST_INIT : ST_RECOVER;
            ST_INIT:    next_state = ST_READY;
            default: begin
                prep_like = 1'b1;
                if (hs.ack) begin
                    next_state = ST_RECOVER;
                    token_miss = 1'b1;
                end else if (prep_cnt == '0) begin
                    next_state = ST_READY;
                end else begin
                    next_state = ST_PREP;
                end
            end
        endcase
    end

    // State, prep countdown, registered handshake outputs and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= ST_PREP;
            prep_cnt   <= PREP_LOAD;
            hs.done    <= 1'b0;
            hs.init    <= 1'b0;
            hs.ready   <= 1'b0;
            served_cnt <= '0;
            nack_cnt   <= '0;
        end else begin
            cur_state <= next_state;
            hs.done   <= (next_state == ST_DONE);
            hs.init   <= (next_state == ST_INIT);
            hs.ready  <= (next_state == ST_READY);

            if (next_state == ST_PREP && !prep_like) begin
                prep_cnt <= PREP_LOAD;
            end else if ((prep_like || cur_state == ST_RECOVER) && prep_cnt != '0) begin
                prep_cnt <= prep_cnt - PREP_W'(1);
            end

            if (token_hit && served_cnt != CNT_MAX) begin
                served_cnt <= served_cnt + CNT_W'(1);
            end
            if (token_miss && nack_cnt != CNT_MAX) begin
                nack_cnt <= nack_cnt + CNT_W'(1);
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_handshake_responder.sv
// Bench for handshake_responder: a WORK_CYCLES=4 / CNT_W=2 instance driven by a
// vector table through an expected-result queue, plus a WORK_CYCLES=1 instance
// exercised by hand around an asynchronous mid-cycle reset.
module tb_handshake_responder;

    typedef struct {
        logic       start;
        logic       ack;
        logic       done;
        logic       init;
        logic       ready;
        logic [2:0] state;
        logic [1:0] served;
        logic [1:0] nack;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] state4;
    logic [1:0] served4;
    logic [1:0] nack4;
    logic [2:0] state1;
    logic [7:0] served1;
    logic [7:0] nack1;

    int n_compared;
    int n_mismatched;

    vec_t vecs[$];
    vec_t exp_q[$];

    handshake_responder_if hs4 ();
    handshake_responder_if hs1 ();

    handshake_responder #(.WORK_CYCLES(4), .CNT_W(2)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .hs         (hs4),
        .state      (state4),
        .served_cnt (served4),
        .nack_cnt   (nack4)
    );

    handshake_responder #(.WORK_CYCLES(1), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .hs         (hs1),
        .state      (state1),
        .served_cnt (served1),
        .nack_cnt   (nack1)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic addVec(input logic s, input logic a, input logic d, input logic i,
                          input logic r, input logic [2:0] st, input logic [1:0] sv,
                          input logic [1:0] nk);
        vec_t v;
        v.start = s; v.ack = a; v.done = d; v.init = i; v.ready = r;
        v.state = st; v.served = sv; v.nack = nk;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        hs4.start = v.start;
        hs4.ack   = v.ack;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkVal($sformatf("v%0d.queue_empty", idx), 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            checkVal($sformatf("v%0d.done", idx),   {7'd0, hs4.done},  {7'd0, e.done});
            checkVal($sformatf("v%0d.init", idx),   {7'd0, hs4.init},  {7'd0, e.init});
            checkVal($sformatf("v%0d.ready", idx),  {7'd0, hs4.ready}, {7'd0, e.ready});
            checkVal($sformatf("v%0d.state", idx),  {5'd0, state4},    {5'd0, e.state});
            checkVal($sformatf("v%0d.served", idx), {6'd0, served4},   {6'd0, e.served});
            checkVal($sformatf("v%0d.nack", idx),   {6'd0, nack4},     {6'd0, e.nack});
        end
    endtask

    // Main test sequence.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n     = 1'b0;
        hs4.start = 1'b0;
        hs4.ack   = 1'b0;
        hs1.start = 1'b0;
        hs1.ack   = 1'b0;

        //     s  a  d  i  r  st  sv nk   (outputs after the edge)
        addVec(0, 0, 0, 0, 0, 0, 0, 0);  // 1  PREP
        addVec(1, 0, 0, 0, 0, 0, 0, 0);  // 2  start in PREP ignored
        addVec(0, 0, 0, 0, 0, 0, 0, 0);  // 3
        addVec(0, 0, 0, 0, 1, 1, 0, 0);  // 4  READY from edge 4
        addVec(1, 0, 1, 0, 0, 2, 1, 0);  // 5  DONE
        addVec(0, 0, 0, 0, 0, 0, 1, 0);  // 6  PREP
        addVec(0, 0, 0, 0, 0, 0, 1, 0);  // 7
        addVec(0, 0, 0, 0, 0, 0, 1, 0);  // 8
        addVec(0, 0, 0, 0, 0, 0, 1, 0);  // 9
        addVec(0, 0, 0, 0, 1, 1, 1, 0);  // 10 READY five cycles after done
        addVec(0, 0, 0, 0, 1, 1, 1, 0);  // 11 idle
        addVec(1, 1, 0, 1, 0, 4, 1, 1);  // 12 start+ack -> INIT
        addVec(0, 0, 0, 0, 1, 1, 1, 1);  // 13 READY, token kept
        addVec(1, 0, 1, 0, 0, 2, 2, 1);  // 14 DONE
        addVec(0, 0, 0, 0, 0, 0, 2, 1);  // 15 PREP cnt3
        addVec(1, 0, 0, 0, 0, 0, 2, 1);  // 16 start ignored, cnt2
        addVec(0, 0, 0, 0, 0, 0, 2, 1);  // 17 cnt1
        addVec(0, 1, 0, 0, 0, 3, 2, 2);  // 18 RECOVER with cnt0
        addVec(0, 1, 0, 1, 0, 4, 2, 2);  // 19 INIT next cycle
        addVec(0, 0, 0, 0, 1, 1, 2, 2);  // 20 READY
        addVec(1, 0, 1, 0, 0, 2, 3, 2);  // 21 DONE
        addVec(0, 0, 0, 0, 0, 0, 3, 2);  // 22 PREP cnt3
        addVec(0, 1, 0, 0, 0, 3, 3, 3);  // 23 RECOVER cnt2
        addVec(1, 1, 0, 0, 0, 3, 3, 3);  // 24 cnt1, start ignored
        addVec(0, 1, 0, 0, 0, 3, 3, 3);  // 25 cnt0
        addVec(0, 1, 0, 1, 0, 4, 3, 3);  // 26 INIT
        addVec(0, 0, 0, 0, 1, 1, 3, 3);  // 27 READY
        addVec(1, 0, 1, 0, 0, 2, 3, 3);  // 28 DONE, served saturated
        addVec(0, 0, 0, 0, 0, 0, 3, 3);  // 29 PREP
        addVec(0, 1, 0, 0, 0, 3, 3, 3);  // 30 RECOVER, nack saturated
        addVec(0, 1, 0, 0, 0, 3, 3, 3);  // 31
        addVec(0, 1, 0, 0, 0, 3, 3, 3);  // 32
        addVec(0, 1, 0, 1, 0, 4, 3, 3);  // 33 INIT
        addVec(0, 0, 0, 0, 1, 1, 3, 3);  // 34 READY
        addVec(1, 0, 1, 0, 0, 2, 3, 3);  // 35 DONE (fifth transaction)
        addVec(0, 0, 0, 0, 0, 0, 3, 3);  // 36 PREP

        #2;
        checkVal("reset.state", {5'd0, state4}, 8'd0);
        checkVal("reset.done",  {7'd0, hs4.done}, 8'd0);
        checkVal("reset.init",  {7'd0, hs4.init}, 8'd0);
        checkVal("reset.ready", {7'd0, hs4.ready}, 8'd0);
        checkVal("reset.served", {6'd0, served4}, 8'd0);
        checkVal("reset.nack",  {6'd0, nack4}, 8'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i + 1);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a RECOVER cycle.
        hs4.start = 1'b0;
        hs4.ack   = 1'b1;
        @(posedge clk);
        #1;
        checkVal("arst.pre_state", {5'd0, state4}, 8'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("arst.state",  {5'd0, state4}, 8'd0);
        checkVal("arst.done",   {7'd0, hs4.done}, 8'd0);
        checkVal("arst.init",   {7'd0, hs4.init}, 8'd0);
        checkVal("arst.served", {6'd0, served4}, 8'd0);
        checkVal("arst.nack",   {6'd0, nack4}, 8'd0);
        hs4.ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle preparation alongside the four-cycle instance.
        @(posedge clk);
        #1;
        checkVal("w1.e1.state", {5'd0, state1}, 8'd1);
        checkVal("w1.e1.ready", {7'd0, hs1.ready}, 8'd1);
        checkVal("w4.e1.state", {5'd0, state4}, 8'd0);
        @(negedge clk);
        hs1.start = 1'b1;
        @(posedge clk);
        #1;
        checkVal("w1.e2.done",   {7'd0, hs1.done}, 8'd1);
        checkVal("w1.e2.served", served1, 8'd1);
        @(negedge clk);
        hs1.start = 1'b0;
        @(posedge clk);
        #1;
        checkVal("w1.e3.state", {5'd0, state1}, 8'd0);
        checkVal("w1.e3.done",  {7'd0, hs1.done}, 8'd0);
        @(posedge clk);
        #1;
        checkVal("w1.e4.ready", {7'd0, hs1.ready}, 8'd1);
        checkVal("w4.e4.ready", {7'd0, hs4.ready}, 8'd1);
        checkVal("w4.e4.state", {5'd0, state4}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
